// File: rtl/mem_stage_sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// arm_mem_pkg
// Shared types and default constants for the MEM-stage SRAM controller.
//   mem_state_e  : controller FSM states (IDLE, LOW, HIGH, DONE)
//   DEF_*        : default BASE_ADDR / WAIT_CYCLES / ADDR_W values
//   sram_addr_t  : SRAM half-word address at the default width
// -----------------------------------------------------------------------------
package arm_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } mem_state_e;

   localparam int unsigned DEF_BASE_ADDR   = 1024;
   localparam int unsigned DEF_WAIT_CYCLES = 2;
   localparam int unsigned DEF_ADDR_W      = 18;

   typedef logic [DEF_ADDR_W-1:0] sram_addr_t;

endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_stage_sram_ctrl_if
// Pipeline-side bundle between the EXE/MEM register and the MEM-stage
// controller.
//   memReadEn / memWriteEn : load / store request
//   aluResult              : byte address from EXE
//   storeData              : store value (Rm)
//   readData               : loaded word towards WB
//   ready                  : 0 freezes the pipeline
// Modports: master = pipeline side, slave = controller side.
// -----------------------------------------------------------------------------
interface mem_stage_sram_ctrl_if;

   logic        memReadEn;
   logic        memWriteEn;
   logic [31:0] aluResult;
   logic [31:0] storeData;
   logic [31:0] readData;
   logic        ready;

   modport master (
      output memReadEn, memWriteEn, aluResult, storeData,
      input  readData, ready
   );

   modport slave (
      input  memReadEn, memWriteEn, aluResult, storeData,
      output readData, ready
   );

endinterface

// File: rtl/mem_stage_sram_ctrl_xlate.sv
// -----------------------------------------------------------------------------
// mem_addr_xlate
// Combinational byte-address to SRAM half-word address translation.
//   aluResult : byte address from EXE
//   lo_addr   : half-word address of bits [15:0] of the word
//   hi_addr   : half-word address of bits [31:16] of the word
// The offset from BASE_ADDR wraps in 32 bits and the word index wraps
// modulo the SRAM size; there is no range check.
// -----------------------------------------------------------------------------
module mem_addr_xlate
   import arm_mem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'(DEF_BASE_ADDR),
   parameter int unsigned ADDR_W    = DEF_ADDR_W
) (
   input  logic [31:0]       aluResult,
   output logic [ADDR_W-1:0] lo_addr,
   output logic [ADDR_W-1:0] hi_addr
);

   logic [31:0] off;
   logic        unused_off_bits;

   assign off     = aluResult - BASE_ADDR;
   assign lo_addr = {off[ADDR_W:2], 1'b0};
   assign hi_addr = {off[ADDR_W:2], 1'b1};

   // Byte-in-word bits and bits above the SRAM size are dropped on purpose.
   assign unused_off_bits = ^{off[31:ADDR_W+1], off[1:0]};

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_sram_ctrl
// MEM-stage load/store controller. A 32-bit access is split into two 16-bit
// accesses (low half, then high half) to an asynchronous SRAM, each held for
// WAIT_CYCLES clocks. ready is low from the request cycle until the DONE
// cycle, freezing the pipeline.
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   bus        : pipeline-side interface (slave modport)
//   SRAM_DQ    : SRAM data bus, driven only during LOW/HIGH of a store
//   SRAM_ADDR  : SRAM half-word address
//   SRAM_WE_N  : SRAM write enable, active low
//   stallCount : saturating count of ready==0 cycles (MEM_STALL_CNT_EN only)
// Configuration macro: MEM_STALL_CNT_EN adds the stallCount port and counter.
// -----------------------------------------------------------------------------
module mem_stage_sram_ctrl
   import arm_mem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'(DEF_BASE_ADDR),
   parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
   parameter int unsigned ADDR_W      = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   mem_stage_sram_ctrl_if.slave bus,
   inout  wire  [15:0]       SRAM_DQ,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic              SRAM_WE_N
`ifdef MEM_STALL_CNT_EN
   ,
   output logic [31:0]       stallCount
`endif
);

   localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

   mem_state_e        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] lo_addr_q, lo_addr_d;
   logic [ADDR_W-1:0] hi_addr_q, hi_addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              wr_q, wr_d;
   logic [31:0]       rdata_q, rdata_d;

   logic [ADDR_W-1:0] xl_lo, xl_hi;
   logic              req;
   logic              last;
   logic              ready_c;
   logic [ADDR_W-1:0] addr_c;
   logic              we_n_c;
   logic              dq_oe;
   logic [15:0]       dq_out;

   mem_addr_xlate #(
      .BASE_ADDR (BASE_ADDR),
      .ADDR_W    (ADDR_W)
   ) u_xlate (
      .aluResult (bus.aluResult),
      .lo_addr   (xl_lo),
      .hi_addr   (xl_hi)
   );

   assign req  = bus.memReadEn | bus.memWriteEn;
   assign last = (cnt_q == LAST_CNT);

   // State register and datapath flops
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         lo_addr_q <= '0;
         hi_addr_q <= '0;
         wdata_q   <= '0;
         wr_q      <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         lo_addr_q <= lo_addr_d;
         hi_addr_q <= hi_addr_d;
         wdata_q   <= wdata_d;
         wr_q      <= wr_d;
         rdata_q   <= rdata_d;
      end
   end

   // Next-state logic; requests presented during DONE belong to the
   // instruction that is leaving the stage, so DONE always returns to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req)  state_d = LOW;
         LOW:     if (last) state_d = HIGH;
         HIGH:    if (last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request latch, wait counter and read capture
   always_comb begin
      cnt_d     = cnt_q;
      lo_addr_d = lo_addr_q;
      hi_addr_d = hi_addr_q;
      wdata_d   = wdata_q;
      wr_d      = wr_q;
      rdata_d   = rdata_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               lo_addr_d = xl_lo;
               hi_addr_d = xl_hi;
               wdata_d   = bus.storeData;
               // Both enables high is illegal and resolves to a store.
               wr_d      = bus.memWriteEn;
               cnt_d     = '0;
            end
         end
         LOW, HIGH: begin
            if (last) begin
               cnt_d = '0;
               if (!wr_q) begin
                  if (state_q == LOW) rdata_d[15:0]  = SRAM_DQ;
                  else                rdata_d[31:16] = SRAM_DQ;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: ;
      endcase
   end

   // Outputs; ready in IDLE is combinational so a new request stalls in
   // the very cycle it arrives.
   always_comb begin
      ready_c = 1'b0;
      addr_c  = '0;
      we_n_c  = 1'b1;
      dq_oe   = 1'b0;
      dq_out  = wdata_q[15:0];
      case (state_q)
         IDLE: ready_c = ~req;
         LOW: begin
            addr_c = lo_addr_q;
            we_n_c = ~wr_q;
            dq_oe  = wr_q;
         end
         HIGH: begin
            addr_c = hi_addr_q;
            we_n_c = ~wr_q;
            dq_oe  = wr_q;
            dq_out = wdata_q[31:16];
         end
         DONE: ready_c = 1'b1;
         default: ;
      endcase
   end

   assign bus.ready    = ready_c;
   assign bus.readData = rdata_q;
   assign SRAM_ADDR    = addr_c;
   assign SRAM_WE_N    = we_n_c;
   assign SRAM_DQ      = dq_oe ? dq_out : 16'hzzzz;

`ifdef MEM_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) stall_cnt_q <= '0;
      else      stall_cnt_q <= stall_cnt_d;
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!ready_c && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   assign stallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_sram_ctrl
// Bench for mem_stage_sram_ctrl: asynchronous SRAM model on the SRAM pins,
// directed scenarios followed by random loads/stores, and a monitor that
// scores every completed access against a word-level reference memory.
// Honours MEM_STALL_CNT_EN for the stallCount port.
// -----------------------------------------------------------------------------
module tb_mem_stage_sram_ctrl;
   import arm_mem_pkg::*;

   localparam int          W    = DEF_WAIT_CYCLES;
   localparam int          AW   = DEF_ADDR_W;
   localparam logic [31:0] BASE = 32'(DEF_BASE_ADDR);
   localparam int          STALL = 1 + 2 * W;

   typedef struct {
      logic [31:0] rd;
      int          stall;
      int          we;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   wire  [15:0]     sram_dq;
   sram_addr_t      sram_addr;
   logic            sram_we_n;
`ifdef MEM_STALL_CNT_EN
   logic [31:0]     stall_count;
`endif

   mem_stage_sram_ctrl_if bus ();

   mem_stage_sram_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .SRAM_DQ    (sram_dq),
      .SRAM_ADDR  (sram_addr),
      .SRAM_WE_N  (sram_we_n)
`ifdef MEM_STALL_CNT_EN
      ,
      .stallCount (stall_count)
`endif
   );

   always #5 clk = ~clk;

   // Asynchronous SRAM: reads are combinational whenever WE_N is high.
   logic [15:0] sram    [0:(1<<AW)-1];
   logic [15:0] ref_mem [0:(1<<AW)-1];
   assign sram_dq = sram_we_n ? sram[sram_addr] : 16'hzzzz;

   initial begin
      forever begin
         @(posedge clk);
         if (!sram_we_n) sram[sram_addr] = sram_dq;
      end
   end

   int          checks = 0;
   int          errors = 0;
   exp_t        exp_q[$];
   logic [31:0] model_rd = 32'h0;
   longint      model_stall = 0;

   function automatic logic [15:0] init_val(input int i);
      return 16'(i * 40503) ^ 16'h3C5A;
   endfunction

   // Half-word address of the low half: word index of the offset, times two.
   function automatic sram_addr_t lo_of(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return sram_addr_t'((off >> 2) << 1);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Presents one request at posedge+1 and holds it until the DONE cycle.
   task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input bit track);
      exp_t       e;
      sram_addr_t lo, hi;
      int         n;
      lo = lo_of(a);
      hi = lo + 1'b1;
      if (track) begin
         if (wr) begin
            ref_mem[lo] = d[15:0];
            ref_mem[hi] = d[31:16];
            e.we = 2 * W;
         end else begin
            model_rd = {ref_mem[hi], ref_mem[lo]};
            e.we = 0;
         end
         e.rd    = model_rd;
         e.stall = STALL;
         model_stall += STALL;
         exp_q.push_back(e);
      end
      bus.memReadEn  = rd;
      bus.memWriteEn = wr;
      bus.aluResult  = a;
      bus.storeData  = d;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.ready && n < 100);
      if (!bus.ready) begin
         checks++;
         errors++;
         $display("FAIL access_timeout: ready still %b after %0d cycles, expected 1", bus.ready, n);
      end
      @(posedge clk);
      #1;
      bus.memReadEn  = 1'b0;
      bus.memWriteEn = 1'b0;
   endtask

   // Monitor: measures each freeze and scores it when ready returns high.
   initial begin
      int   run;
      int   we_run;
      exp_t e;
      run = 0;
      we_run = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            run = 0;
            we_run = 0;
         end else if (!bus.ready) begin
            run++;
            if (!sram_we_n) we_run++;
         end else begin
            chk("we_n_when_ready", 32'(sram_we_n), 32'd1);
            if (run > 0) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_access: freeze of %0d cycles, expected none", run);
               end else begin
                  e = exp_q.pop_front();
                  chk("freeze_len", 32'(run), 32'(e.stall));
                  chk("we_low_len", 32'(we_run), 32'(e.we));
                  chk("read_data", bus.readData, e.rd);
               end
               run = 0;
               we_run = 0;
            end
         end
      end
   end

   initial begin
      int          n;
      logic [31:0] a, d;
      logic [1:0]  op;
      for (int i = 0; i < (1 << AW); i++) begin
         sram[i]    = init_val(i);
         ref_mem[i] = init_val(i);
      end
      bus.memReadEn  = 1'b0;
      bus.memWriteEn = 1'b0;
      bus.aluResult  = '0;
      bus.storeData  = '0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(bus.ready), 32'd1);
      chk("rst_readData", bus.readData, 32'h0);
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_addr", 32'(sram_addr), 32'h0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Directed store
      issue(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b1);
      chk("store_lo", 32'(sram[0]), 32'h0000BEEF);
      chk("store_hi", 32'(sram[1]), 32'h0000DEAD);

      // Directed load
      sram[2] = 16'h5678; ref_mem[2] = 16'h5678;
      sram[3] = 16'h1234; ref_mem[3] = 16'h1234;
      issue(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1);
      chk("load_word", bus.readData, 32'h12345678);

      // No request for 10 cycles
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_ready", 32'(bus.ready), 32'd1);
         chk("idle_we_n", 32'(sram_we_n), 32'd1);
      end
      @(posedge clk);
      #1;

      // Reset in the 2nd LOW cycle of a store to 1032 (half-words 4 and 5)
      d = 32'hC0DE_F00D;
      bus.aluResult  = 32'd1032;
      bus.storeData  = d;
      bus.memWriteEn = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      bus.memWriteEn = 1'b0;
      #1;
      chk("midrst_we_n", 32'(sram_we_n), 32'd1);
      chk("midrst_addr", 32'(sram_addr), 32'h0);
      chk("midrst_readData", bus.readData, 32'h0);
      chk("midrst_ready", 32'(bus.ready), 32'd1);
      model_rd = 32'h0;
      ref_mem[4] = d[15:0];
      model_stall = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("midrst_hi_unwritten", 32'(sram[5]), 32'(init_val(5)));
      chk("midrst_lo_partial", 32'(sram[4]), 32'(d[15:0]));
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Back-to-back store then load
      issue(1'b0, 1'b1, 32'd1024, 32'h0000AAAA, 1'b1);
      issue(1'b1, 1'b0, 32'd1024, 32'h0, 1'b1);
      chk("b2b_load", bus.readData, 32'h0000AAAA);
`ifdef MEM_STALL_CNT_EN
      chk("stall_count_b2b", stall_count, 32'd10);
`endif

      // Random loads/stores; both enables high counts as a store
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 0)
            a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
         else
            a = $urandom();
         d = $urandom();
         case (op)
            2'd0, 2'd3: issue(1'b1, 1'b0, a, d, 1'b1);
            2'd1:       issue(1'b0, 1'b1, a, d, 1'b1);
            default:    issue(1'b1, 1'b1, a, d, 1'b1);
         endcase
         if ($urandom_range(0, 3) == 0) begin
            n = $urandom_range(1, 3);
            repeat (n) @(posedge clk);
            #1;
         end
      end

      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
`ifdef MEM_STALL_CNT_EN
      chk("stall_count_total", stall_count, 32'(model_stall));
`endif
      for (int i = 0; i < 8; i++) chk("mem_image", 32'(sram[i]), 32'(ref_mem[i]));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
